haar_stage_sequencer: RTL and testbench

Controller that walks the stage database for one candidate window. For each stage it reads the classifier count and stage threshold from the stage memory. It then issues that many classifier-evaluation requests, accumulates their signed results and compares the sum against the threshold. The window is rejected at the first failing stage, or reported as a face after the last stage; the block sits between the window scanner and the stage ROM / classifier engine.

---
 rtl/haar_stage_sequencer_pkg.sv | 22 ++
 rtl/haar_stage_accumulator.sv | 48 ++++
 rtl/haar_stage_sequencer.sv | 177 +++++++++++++++++
 tb/tb_haar_stage_sequencer.sv | 540 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/haar_stage_sequencer_pkg.sv
// Shared definitions for the Haar cascade stage sequencer: FSM state
// encoding, layout of a stage record in the stage memory, default depth.
package haar_stage_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_CNT = 4'd1,
    ST_WT_CNT = 4'd2,
    ST_RD_THR = 4'd3,
    ST_WT_THR = 4'd4,
    ST_REQ    = 4'd5,
    ST_WAIT   = 4'd6,
    ST_CMP    = 4'd7,
    ST_FIN    = 4'd8
  } state_e;

  // Each stage occupies two consecutive words: classifier count, then threshold.
  localparam int COUNT_OFS      = 0;
  localparam int THR_OFS        = 1;
  localparam int SIZE_STAGE_DEF = 10;

endpackage

// File: rtl/haar_stage_accumulator.sv
// Signed saturating accumulator for classifier results, with a clear and a
// signed ">= threshold" compare against a sign-extended 16-bit threshold.
module haar_stage_accumulator #(
  parameter int ACC_WIDTH  = 24,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  add_i,
  input  logic [DATA_WIDTH-1:0] value_i,
  input  logic [DATA_WIDTH-1:0] thr_i,
  output logic                  pass_o
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] thr_ext;

  // Next accumulator value: clear wins, otherwise add with clamping on overflow.
  always_comb begin
    sum_wide = {acc_q[ACC_WIDTH-1], acc_q}
             + {{(ACC_WIDTH+1-DATA_WIDTH){value_i[DATA_WIDTH-1]}}, value_i};
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
        acc_d = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
      end else begin
        acc_d = sum_wide[ACC_WIDTH-1:0];
      end
    end
  end

  assign thr_ext = {{(ACC_WIDTH-DATA_WIDTH){thr_i[DATA_WIDTH-1]}}, thr_i};
  assign pass_o  = $signed(acc_q) >= $signed(thr_ext);

  // Accumulator register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) acc_q <= '0;
    else        acc_q <= acc_d;
  end

endmodule

// File: rtl/haar_stage_sequencer.sv
// Walks the stage database for one candidate window: reads count and
// threshold per stage, issues classifier requests, accumulates the results
// and rejects at the first failing stage or reports a face after the last.
//
// Handshakes: the stage memory returns i_stage_data exactly one cycle after
// a single-cycle o_stage_ren pulse (address stable during that pulse).
// o_clf_req/o_clf_index stay asserted until a cycle with i_clf_valid high;
// that cycle consumes i_clf_value, and o_clf_req is then low for at least
// one cycle before the next request. i_clf_valid without o_clf_req is ignored.
module haar_stage_sequencer
  import haar_stage_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int DATA_WIDTH_16 = 16,
  parameter int SIZE_STAGE    = SIZE_STAGE_DEF,
  parameter int ACC_WIDTH     = 24,
  parameter int CLF_IDX_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic                     i_abort,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_face,
  output logic [7:0]               o_fail_stage,
  output logic                     o_stage_ren,
  output logic [ADDR_WIDTH-1:0]    o_stage_addr,
  input  logic [DATA_WIDTH_16-1:0] i_stage_data,
  output logic                     o_clf_req,
  output logic [CLF_IDX_WIDTH-1:0] o_clf_index,
  input  logic                     i_clf_valid,
  input  logic [DATA_WIDTH_16-1:0] i_clf_value,
  output logic [3:0]               o_dbg_state
);

  state_e                   state_q;
  logic [7:0]               stage_q;
  logic [DATA_WIDTH_16-1:0] remaining_q;
  logic [DATA_WIDTH_16-1:0] thr_q;
  logic [CLF_IDX_WIDTH-1:0] clf_idx_q;
  logic                     busy_q, done_q, face_q, ren_q, req_q;
  logic [7:0]               fail_stage_q;
  logic [ADDR_WIDTH-1:0]    addr_q;

  logic abort, last_stage, acc_clear, acc_add, acc_pass;

  function automatic logic [ADDR_WIDTH-1:0] stage_addr(input logic [7:0] s, input int ofs);
    return ADDR_WIDTH'({s, 1'b0}) + ADDR_WIDTH'(ofs);
  endfunction

  assign abort      = i_abort && (state_q != ST_IDLE);
  assign last_stage = (stage_q == 8'(SIZE_STAGE - 1));
  assign acc_add    = (state_q == ST_WAIT) && i_clf_valid && !i_abort;
  assign acc_clear  = ((state_q == ST_IDLE) && i_start)
                    || ((state_q == ST_CMP) && acc_pass && !last_stage && !i_abort);

  haar_stage_accumulator #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH_16)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clear_i (acc_clear),
    .add_i   (acc_add),
    .value_i (i_clf_value),
    .thr_i   (thr_q),
    .pass_o  (acc_pass)
  );

  // Stage walk FSM; every output is registered and set on entry to its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      stage_q      <= '0;
      remaining_q  <= '0;
      thr_q        <= '0;
      clf_idx_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      face_q       <= 1'b0;
      fail_stage_q <= '0;
      ren_q        <= 1'b0;
      addr_q       <= '0;
      req_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        req_q   <= 1'b0;
        ren_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (i_start) begin
              state_q      <= ST_RD_CNT;
              busy_q       <= 1'b1;
              stage_q      <= '0;
              clf_idx_q    <= '0;
              face_q       <= 1'b0;
              fail_stage_q <= '0;
              ren_q        <= 1'b1;
              addr_q       <= stage_addr(8'd0, COUNT_OFS);
            end
          end
          ST_RD_CNT: begin
            ren_q   <= 1'b0;
            state_q <= ST_WT_CNT;
          end
          ST_WT_CNT: begin
            remaining_q <= i_stage_data;
            ren_q       <= 1'b1;
            addr_q      <= stage_addr(stage_q, THR_OFS);
            state_q     <= ST_RD_THR;
          end
          ST_RD_THR: begin
            ren_q   <= 1'b0;
            state_q <= ST_WT_THR;
          end
          ST_WT_THR: begin
            thr_q   <= i_stage_data;
            state_q <= (remaining_q != '0) ? ST_REQ : ST_CMP;
          end
          ST_REQ: begin
            // Entered with o_clf_req low, which gives the gap between requests.
            req_q   <= 1'b1;
            state_q <= ST_WAIT;
          end
          ST_WAIT: begin
            if (i_clf_valid) begin
              req_q       <= 1'b0;
              clf_idx_q   <= clf_idx_q + 1'b1;
              remaining_q <= remaining_q - 1'b1;
              state_q     <= (remaining_q == DATA_WIDTH_16'(1)) ? ST_CMP : ST_REQ;
            end
          end
          ST_CMP: begin
            if (acc_pass) begin
              if (last_stage) begin
                face_q       <= 1'b1;
                fail_stage_q <= 8'(SIZE_STAGE);
                state_q      <= ST_FIN;
              end else begin
                stage_q <= stage_q + 8'd1;
                ren_q   <= 1'b1;
                addr_q  <= stage_addr(stage_q + 8'd1, COUNT_OFS);
                state_q <= ST_RD_CNT;
              end
            end else begin
              face_q       <= 1'b0;
              fail_stage_q <= stage_q;
              state_q      <= ST_FIN;
            end
          end
          ST_FIN: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_face       = face_q;
  assign o_fail_stage = fail_stage_q;
  assign o_stage_ren  = ren_q;
  assign o_stage_addr = addr_q;
  assign o_clf_req    = req_q;
  assign o_clf_index  = clf_idx_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_haar_stage_sequencer.sv
// Bench for haar_stage_sequencer with a two-stage database: stage memory and
// classifier engine models, a cascade reference model and scenario tasks.
module tb_haar_stage_sequencer;

  localparam int NS = 2;
  localparam int AW = 10;
  localparam int DW = 16;
  localparam int CW = 12;
  localparam longint ACC_MAX = 64'sd8388607;
  localparam longint ACC_MIN = -64'sd8388608;

  logic          clk, reset, i_start, i_abort;
  logic          o_busy, o_done, o_face, o_stage_ren, o_clf_req;
  logic [7:0]    o_fail_stage;
  logic [AW-1:0] o_stage_addr;
  logic [DW-1:0] i_stage_data, i_clf_value;
  logic [CW-1:0] o_clf_index;
  logic          i_clf_valid;
  logic [3:0]    dbg_state;

  haar_stage_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH_16(DW), .SIZE_STAGE(NS), .ACC_WIDTH(24), .CLF_IDX_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .o_busy(o_busy), .o_done(o_done), .o_face(o_face), .o_fail_stage(o_fail_stage),
    .o_stage_ren(o_stage_ren), .o_stage_addr(o_stage_addr), .i_stage_data(i_stage_data),
    .o_clf_req(o_clf_req), .o_clf_index(o_clf_index), .i_clf_valid(i_clf_valid),
    .i_clf_value(i_clf_value), .o_dbg_state(dbg_state)
  );

  // Clock and cycle counter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Scenario data and scoreboard.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            cnt [NS];
  int            thr [NS];
  int            res_list[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [CW-1:0] exp_idx_q[$];
  int            exp_ren_rel[$];
  bit            exp_face;
  int            exp_fail;
  int            exp_lat;

  logic [AW-1:0] addr_obs[$];
  int            ren_cyc_obs[$];
  logic [CW-1:0] idx_obs[$];
  int            ren_err, gap_err;
  logic [DW-1:0] res_q[$];
  bit            resp_en, noise_en;
  int            resp_wait;

  // Stage memory: data for a read appears during the cycle after o_stage_ren.
  initial begin : mem_model
    logic          pend_ren, prev_ren;
    logic [AW-1:0] pend_addr;
    i_stage_data = '0;
    prev_ren = 1'b0;
    forever begin
      @(negedge clk);
      pend_ren  = o_stage_ren;
      pend_addr = o_stage_addr;
      if (pend_ren) begin
        addr_obs.push_back(pend_addr);
        ren_cyc_obs.push_back(cyc);
        if (prev_ren) ren_err++;
      end
      prev_ren = pend_ren;
      @(posedge clk);
      #1;
      i_stage_data = pend_ren ? mem[pend_addr] : 16'($urandom);
    end
  end

  // Classifier engine: answers a request after 0..2 cycles; optional noise strobes.
  initial begin : clf_model
    bit prev_taken;
    resp_wait  = 0;
    prev_taken = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_taken && o_clf_req) gap_err++;
      prev_taken = 1'b0;
      if (resp_en) begin
        i_clf_valid = 1'b0;
        if (o_clf_req) begin
          if (resp_wait == 0 && res_q.size() > 0) begin
            i_clf_valid = 1'b1;
            i_clf_value = res_q.pop_front();
            idx_obs.push_back(o_clf_index);
            prev_taken = 1'b1;
            resp_wait  = $urandom_range(0, 2);
          end else if (resp_wait > 0) begin
            resp_wait--;
          end
        end else if (noise_en && $urandom_range(0, 3) == 0) begin
          i_clf_valid = 1'b1;
          i_clf_value = 16'($urandom);
        end
      end
    end
  end

  // Cascade reference: per stage sum results with clamping, stop at first miss.
  task automatic model_window();
    longint acc;
    int k, visited;
    exp_addr_q.delete();
    exp_idx_q.delete();
    exp_ren_rel.delete();
    exp_face = 1'b1;
    exp_fail = NS;
    k = 0;
    visited = 0;
    for (int s = 0; s < NS; s++) begin
      visited++;
      exp_addr_q.push_back(AW'(2 * s));
      exp_addr_q.push_back(AW'(2 * s + 1));
      acc = 0;
      for (int j = 0; j < cnt[s]; j++) begin
        acc = acc + longint'(res_list[k]);
        if (acc > ACC_MAX) acc = ACC_MAX;
        if (acc < ACC_MIN) acc = ACC_MIN;
        exp_idx_q.push_back(CW'(k));
        k++;
      end
      if (acc < longint'(thr[s])) begin
        exp_face = 1'b0;
        exp_fail = s;
        break;
      end
    end
    exp_lat = (k == 0) ? 5 * visited + 2 : -1;
    if (k == 0)
      for (int s = 0; s < visited; s++) begin
        exp_ren_rel.push_back(5 * s);
        exp_ren_rel.push_back(5 * s + 2);
      end
  endtask

  // Load the database, start a window, wait for o_done and score the run.
  task automatic run_window(input string name, input bit mid_start);
    int c0, budget, busy_err;
    bit seen;
    for (int s = 0; s < NS; s++) begin
      mem[2 * s]     = 16'(cnt[s]);
      mem[2 * s + 1] = 16'(thr[s]);
    end
    model_window();
    res_q.delete();
    foreach (res_list[i]) res_q.push_back(16'(res_list[i]));
    addr_obs.delete();
    ren_cyc_obs.delete();
    idx_obs.delete();
    ren_err = 0;
    gap_err = 0;
    budget = 5 * NS + 10;
    for (int s = 0; s < NS; s++) budget += 6 * cnt[s];
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    c0 = cyc;
    seen = 1'b0;
    busy_err = 0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (mid_start) i_start = (n == 3);
      if (o_done) begin
        seen = 1'b1;
        break;
      end
      if (!o_busy) busy_err++;
    end
    i_start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s done_timeout: got no o_done want o_done within %0d cycles", name, budget);
    end
    total++;
    if (o_face !== exp_face) begin
      bad++;
      $display("FAIL %s face: got %0b want %0b", name, o_face, exp_face);
    end
    total++;
    if (o_fail_stage !== 8'(exp_fail)) begin
      bad++;
      $display("FAIL %s fail_stage: got %0d want %0d", name, o_fail_stage, exp_fail);
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_at_done: got %0b want 0", name, o_busy);
    end
    total++;
    if (busy_err !== 0) begin
      bad++;
      $display("FAIL %s busy_during_run: got %0d low cycles want 0", name, busy_err);
    end
    if (exp_lat >= 0) begin
      total++;
      if (cyc - c0 + 1 !== exp_lat) begin
        bad++;
        $display("FAIL %s latency: got %0d want %0d", name, cyc - c0 + 1, exp_lat);
      end
      total++;
      if (ren_cyc_obs.size() !== exp_ren_rel.size()) begin
        bad++;
        $display("FAIL %s ren_count: got %0d want %0d", name, ren_cyc_obs.size(), exp_ren_rel.size());
      end else begin
        for (int i = 0; i < exp_ren_rel.size(); i++) begin
          total++;
          if (ren_cyc_obs[i] - c0 !== exp_ren_rel[i]) begin
            bad++;
            $display("FAIL %s ren_cycle[%0d]: got %0d want %0d", name, i, ren_cyc_obs[i] - c0, exp_ren_rel[i]);
            break;
          end
        end
      end
    end
    total++;
    if (addr_obs.size() !== exp_addr_q.size()) begin
      bad++;
      $display("FAIL %s read_count: got %0d want %0d", name, addr_obs.size(), exp_addr_q.size());
    end else begin
      for (int i = 0; i < exp_addr_q.size(); i++) begin
        total++;
        if (addr_obs[i] !== exp_addr_q[i]) begin
          bad++;
          $display("FAIL %s read_addr[%0d]: got %0d want %0d", name, i, addr_obs[i], exp_addr_q[i]);
          break;
        end
      end
    end
    total++;
    if (idx_obs.size() !== exp_idx_q.size()) begin
      bad++;
      $display("FAIL %s req_count: got %0d want %0d", name, idx_obs.size(), exp_idx_q.size());
    end else begin
      for (int i = 0; i < exp_idx_q.size(); i++) begin
        total++;
        if (idx_obs[i] !== exp_idx_q[i]) begin
          bad++;
          $display("FAIL %s clf_index[%0d]: got %0d want %0d", name, i, idx_obs[i], exp_idx_q[i]);
          break;
        end
      end
    end
    total++;
    if (ren_err !== 0) begin
      bad++;
      $display("FAIL %s ren_pulse: got %0d long pulses want 0", name, ren_err);
    end
    total++;
    if (gap_err !== 0) begin
      bad++;
      $display("FAIL %s req_gap: got %0d missing gaps want 0", name, gap_err);
    end
    @(negedge clk);
    total++;
    if (o_done !== 1'b0) begin
      bad++;
      $display("FAIL %s done_pulse: got %0b want 0", name, o_done);
    end
    total++;
    if (o_face !== exp_face || o_fail_stage !== 8'(exp_fail)) begin
      bad++;
      $display("FAIL %s result_hold: got %0b/%0d want %0b/%0d", name, o_face, o_fail_stage, exp_face, exp_fail);
    end
  endtask

  task automatic test_reset();
    logic [34:0] outs;
    reset = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    outs = {o_busy, o_done, o_face, o_fail_stage, o_stage_ren, o_stage_addr, o_clf_req, o_clf_index};
    total++;
    if (outs !== 35'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    outs = {o_busy, o_done, o_face, o_fail_stage, o_stage_ren, o_stage_addr, o_clf_req, o_clf_index};
    total++;
    if (outs !== 35'd0) begin
      bad++;
      $display("FAIL idle_outputs: got %h want 0", outs);
    end
  endtask

  task automatic test_face_path();
    cnt = '{2, 1};
    thr = '{10, 0};
    res_list = '{6, 5, 3};
    run_window("face_path", 1'b0);
  endtask

  task automatic test_early_reject();
    cnt = '{3, 1};
    thr = '{100, 0};
    res_list = '{40, 40, 19, 7};
    run_window("early_reject", 1'b0);
  endtask

  task automatic test_zero_count();
    res_list.delete();
    cnt = '{0, 0};
    thr = '{0, -1};
    run_window("zero_pass", 1'b0);
    thr = '{1, 0};
    run_window("zero_fail", 1'b0);
  endtask

  task automatic test_saturation();
    cnt = '{255, 1};
    thr = '{-32768, 0};
    res_list.delete();
    repeat (256) res_list.push_back(-32768);
    run_window("neg_255", 1'b0);
    cnt = '{300, 1};
    res_list.delete();
    repeat (301) res_list.push_back(-32768);
    run_window("neg_sat", 1'b0);
    cnt = '{300, 1};
    thr = '{32767, -32768};
    res_list.delete();
    repeat (300) res_list.push_back(32767);
    res_list.push_back(-32768);
    run_window("pos_sat", 1'b0);
  endtask

  task automatic test_random();
    logic [DW-1:0] raw;
    for (int w = 0; w < 12; w++) begin
      res_list.delete();
      for (int s = 0; s < NS; s++) begin
        cnt[s] = $urandom_range(0, 4);
        thr[s] = int'($urandom_range(0, 80)) - 40;
        for (int j = 0; j < cnt[s]; j++) begin
          raw = 16'($urandom);
          if ($urandom_range(0, 9) == 0) res_list.push_back(int'($signed(raw)));
          else res_list.push_back(int'($urandom_range(0, 60)) - 30);
        end
      end
      run_window($sformatf("random%0d", w), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_index_wrap();
    cnt = '{2100, 2100};
    thr = '{-32768, 0};
    res_list.delete();
    repeat (4200) res_list.push_back(0);
    run_window("index_wrap", 1'b0);
  endtask

  task automatic test_abort();
    bit got_req;
    int dones, rens;
    cnt = '{3, 1};
    thr = '{100, 0};
    for (int s = 0; s < NS; s++) begin
      mem[2 * s]     = 16'(cnt[s]);
      mem[2 * s + 1] = 16'(thr[s]);
    end
    resp_en = 1'b0;
    i_clf_valid = 1'b0;
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    for (int r = 0; r < 2; r++) begin
      got_req = 1'b0;
      for (int n = 0; n < 40; n++) begin
        @(negedge clk);
        if (o_clf_req) begin
          got_req = 1'b1;
          break;
        end
      end
      total++;
      if (!got_req) begin
        bad++;
        $display("FAIL abort_req%0d: got no o_clf_req want o_clf_req", r);
      end
      if (r == 0) begin
        i_clf_valid = 1'b1;
        i_clf_value = 16'd50;
        @(negedge clk);
        i_clf_valid = 1'b0;
      end
    end
    i_abort = 1'b1;
    i_clf_valid = 1'b1;
    i_clf_value = 16'h7fff;
    @(negedge clk);
    i_abort = 1'b0;
    i_clf_valid = 1'b0;
    total++;
    if (o_clf_req !== 1'b0) begin
      bad++;
      $display("FAIL abort_req_drop: got %0b want 0", o_clf_req);
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_busy_drop: got %0b want 0", o_busy);
    end
    dones = 0;
    rens = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done) dones++;
      if (o_stage_ren || o_clf_req) rens++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
    end
    total++;
    if (rens !== 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", rens);
    end
    resp_en = 1'b1;
    cnt = '{1, 1};
    thr = '{10, 0};
    res_list = '{5, 0};
    run_window("abort_rerun", 1'b0);
  endtask

  task automatic test_reset_mid();
    bit got_req;
    int dones;
    logic [34:0] outs;
    cnt = '{3, 1};
    thr = '{0, 0};
    for (int s = 0; s < NS; s++) begin
      mem[2 * s]     = 16'(cnt[s]);
      mem[2 * s + 1] = 16'(thr[s]);
    end
    resp_en = 1'b0;
    i_clf_valid = 1'b0;
    @(posedge clk);
    #1 i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    got_req = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_clf_req) begin
        got_req = 1'b1;
        break;
      end
    end
    total++;
    if (!got_req) begin
      bad++;
      $display("FAIL rst_mid_req: got no o_clf_req want o_clf_req");
    end
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b1 || o_clf_req !== 1'b1 || o_stage_ren !== 1'b0) begin
      bad++;
      $display("FAIL start_while_busy: got busy=%0b req=%0b ren=%0b want 1/1/0", o_busy, o_clf_req, o_stage_ren);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    outs = {o_busy, o_done, o_face, o_fail_stage, o_stage_ren, o_stage_addr, o_clf_req, o_clf_index};
    total++;
    if (outs !== 35'd0) begin
      bad++;
      $display("FAIL async_reset: got %h want 0", outs);
    end
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_done || o_busy) dones++;
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL reset_no_done: got %0d active cycles want 0", dones);
    end
    resp_en = 1'b1;
    cnt = '{2, 2};
    thr = '{-5, 4};
    res_list = '{-3, 1, 2, 2};
    run_window("after_reset", 1'b0);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_clf_valid = 1'b0;
    i_clf_value = '0;
    resp_en = 1'b1;
    noise_en = 1'b0;
    for (int a = 0; a < (1 << AW); a++) mem[a] = 16'($urandom);
    test_reset();
    test_face_path();
    test_early_reject();
    test_zero_count();
    test_saturation();
    noise_en = 1'b1;
    test_random();
    test_index_wrap();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
